// File: rtl/bcd_seq_add_ctrl_if.sv
// Bundle of signals around the BCD add sequencer.
// It carries the request side (operands, start, result, status) and the
// digit-wide link to the shared external single-digit BCD adder.
// The slave modport is the sequencer's view. The master modport is the view
// of whoever drives requests and provides the adder.
interface bcd_seq_add_ctrl_if #(
   parameter int DIGITS = 4
);
   logic                  start;
   logic [4*DIGITS-1:0]   a_in;
   logic [4*DIGITS-1:0]   b_in;
   logic                  cin;
   logic [3:0]            add_a;
   logic [3:0]            add_b;
   logic                  add_cin;
   logic [3:0]            add_sum;
   logic                  add_cout;
   logic [4*DIGITS-1:0]   sum;
   logic                  cout;
   logic                  busy;
   logic                  done;
   logic                  err;

   modport master (
      output start, a_in, b_in, cin, add_sum, add_cout,
      input  add_a, add_b, add_cin, sum, cout, busy, done, err
   );

   modport slave (
      input  start, a_in, b_in, cin, add_sum, add_cout,
      output add_a, add_b, add_cin, sum, cout, busy, done, err
   );
endinterface

// File: rtl/bcd_seq_add_ctrl.sv
// Multi-digit packed-BCD adder sequencer.
// A single external combinational digit adder is time-shared. One digit pair
// is presented per clock, starting with the least significant digit. The
// carry between digits always passes through the carry register, so there is
// never a combinational path from add_cout back to add_cin.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; adder inputs are held at zero
// RUN   | presenting digit idx to the adder and capturing its sum/carry
// DONE  | result is complete; done is high for this single cycle
module bcd_seq_add_ctrl #(
   parameter int DIGITS = 4,
   parameter int IDXW   = 2
) (
   input logic                clk,
   input logic                rst_n,
   bcd_seq_add_ctrl_if.slave  bus
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [IDXW-1:0] LAST = IDXW'(DIGITS - 1);

   logic [1:0]            state;
   logic [4*DIGITS-1:0]   a_reg;
   logic [4*DIGITS-1:0]   b_reg;
   logic [4*DIGITS-1:0]   sum_reg;
   logic [IDXW-1:0]       idx;
   logic                  carry;
   logic                  cout_reg;
   logic                  err_reg;
   logic [3:0]            dig_a;
   logic [3:0]            dig_b;
   logic                  operands_bad;

   // Returns 1 when any packed digit of v is outside the BCD range 0..9.
   function automatic logic any_bad_digit(input logic [4*DIGITS-1:0] v);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] > 4'd9) bad = 1'b1;
      end
      return bad;
   endfunction

   // Operand check performed on the live inputs, latched only on an accepted start.
   always_comb begin
      operands_bad = any_bad_digit(bus.a_in) | any_bad_digit(bus.b_in);
   end

   // Select digit idx of the latched operands; zero outside RUN.
   always_comb begin
      dig_a = '0;
      dig_b = '0;
      if (state == RUN) begin
         for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDXW'(i)) begin
               dig_a = a_reg[4*i +: 4];
               dig_b = b_reg[4*i +: 4];
            end
         end
      end
   end

   assign bus.add_a   = dig_a;
   assign bus.add_b   = dig_b;
   assign bus.add_cin = (state == RUN) ? carry : 1'b0;
   assign bus.sum     = sum_reg;
   assign bus.cout    = cout_reg;
   assign bus.err     = err_reg;
   assign bus.busy    = (state != IDLE);
   assign bus.done    = (state == DONE);

   // Sequencer: latch operands on start, ripple one digit per clock, then report.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         a_reg    <= '0;
         b_reg    <= '0;
         sum_reg  <= '0;
         idx      <= '0;
         carry    <= 1'b0;
         cout_reg <= 1'b0;
         err_reg  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  a_reg    <= bus.a_in;
                  b_reg    <= bus.b_in;
                  carry    <= bus.cin;
                  idx      <= '0;
                  sum_reg  <= '0;
                  cout_reg <= 1'b0;
                  err_reg  <= operands_bad;
                  state    <= RUN;
               end
            end
            RUN: begin
               for (int i = 0; i < DIGITS; i++) begin
                  if (idx == IDXW'(i)) sum_reg[4*i +: 4] <= bus.add_sum;
               end
               carry <= bus.add_cout;
               // idx holds on the final digit so it never wraps past DIGITS-1
               if (idx == LAST) begin
                  cout_reg <= bus.add_cout;
                  state    <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_seq_add_ctrl.sv
// Directed bench for bcd_seq_add_ctrl with DIGITS=4.
// It provides a behavioural single-digit BCD adder on the adder link and
// checks the sequencer against hand-computed results.
module tb_bcd_seq_add_ctrl;

   logic clk;
   logic rst_n;
   int   n_assert;
   int   n_fail;
   logic [3:0] cins;
   logic       seen;
   logic [4:0] s5;

   bcd_seq_add_ctrl_if #(.DIGITS(4)) bus ();

   bcd_seq_add_ctrl #(.DIGITS(4), .IDXW(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // External combinational single-digit BCD adder
   always_comb begin
      s5 = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {4'b0, bus.add_cin};
      if (s5 > 5'd9) begin
         bus.add_sum  = 4'(s5 - 5'd10);
         bus.add_cout = 1'b1;
      end else begin
         bus.add_sum  = s5[3:0];
         bus.add_cout = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One full operation: start pulse, four RUN cycles, DONE cycle, return to IDLE.
   task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic ci, input logic [15:0] es, input logic ec,
                         input logic ee, input logic chk_res, output logic [3:0] cin_seq);
      bus.a_in  = a;
      bus.b_in  = b;
      bus.cin   = ci;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      chk({tag, ":err"}, {31'd0, bus.err}, {31'd0, ee});
      chk({tag, ":add_a0"}, {28'd0, bus.add_a}, {28'd0, a[3:0]});
      chk({tag, ":add_b0"}, {28'd0, bus.add_b}, {28'd0, b[3:0]});
      for (int k = 0; k < 4; k++) begin
         chk({tag, ":busy_run"}, {31'd0, bus.busy}, 32'd1);
         chk({tag, ":done_run"}, {31'd0, bus.done}, 32'd0);
         cin_seq[k] = bus.add_cin;
         tick();
      end
      chk({tag, ":done"}, {31'd0, bus.done}, 32'd1);
      chk({tag, ":busy_done"}, {31'd0, bus.busy}, 32'd1);
      chk({tag, ":add_a_done"}, {28'd0, bus.add_a}, 32'd0);
      if (chk_res) begin
         chk({tag, ":sum"}, {16'd0, bus.sum}, {16'd0, es});
         chk({tag, ":cout"}, {31'd0, bus.cout}, {31'd0, ec});
      end
      tick();
      chk({tag, ":done_after"}, {31'd0, bus.done}, 32'd0);
      chk({tag, ":busy_after"}, {31'd0, bus.busy}, 32'd0);
      chk({tag, ":err_hold"}, {31'd0, bus.err}, {31'd0, ee});
      if (chk_res) begin
         chk({tag, ":sum_hold"}, {16'd0, bus.sum}, {16'd0, es});
      end
   endtask

   initial begin
      n_assert  = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.a_in  = '0;
      bus.b_in  = '0;
      bus.cin   = 1'b0;
      tick();
      tick();

      // Reset state
      chk("rst:busy", {31'd0, bus.busy}, 32'd0);
      chk("rst:done", {31'd0, bus.done}, 32'd0);
      chk("rst:sum", {16'd0, bus.sum}, 32'd0);
      chk("rst:cout", {31'd0, bus.cout}, 32'd0);
      chk("rst:err", {31'd0, bus.err}, 32'd0);
      chk("rst:add_a", {28'd0, bus.add_a}, 32'd0);
      chk("rst:add_cin", {31'd0, bus.add_cin}, 32'd0);
      rst_n = 1'b1;
      tick();

      // 1234 + 5678 = 6912, carries into digits 0..3: 0,1,1,0
      run_op("t1", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b1, cins);
      chk("t1:cin_seq", {28'd0, cins}, 32'h6);

      // 9999 + 0001 = 1_0000, carry ripples through every digit
      run_op("t2", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, cins);
      chk("t2:cin_seq", {28'd0, cins}, 32'he);

      // Carry-in to digit 0
      run_op("t3", 16'h0001, 16'h0001, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b1, cins);
      chk("t3:cin_seq", {28'd0, cins}, 32'h1);

      // 8 + 8 = 16, decimal adjust in digit 0
      run_op("t4", 16'h0008, 16'h0008, 1'b0, 16'h0016, 1'b0, 1'b0, 1'b1, cins);
      chk("t4:cin_seq", {28'd0, cins}, 32'h2);

      // Start held high, operand changed during RUN: first operands used
      bus.a_in  = 16'h1111;
      bus.b_in  = 16'h2222;
      bus.cin   = 1'b0;
      bus.start = 1'b1;
      tick();
      bus.a_in = 16'h3333;
      for (int k = 0; k < 4; k++) tick();
      chk("hold:done", {31'd0, bus.done}, 32'd1);
      chk("hold:sum", {16'd0, bus.sum}, 32'h3333);
      tick();
      chk("hold:idle_busy", {31'd0, bus.busy}, 32'd0);
      chk("hold:idle_sum", {16'd0, bus.sum}, 32'h3333);
      tick();
      chk("hold:restart_busy", {31'd0, bus.busy}, 32'd1);
      chk("hold:restart_sum", {16'd0, bus.sum}, 32'd0);
      chk("hold:restart_add_a", {28'd0, bus.add_a}, 32'd3);
      bus.start = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      chk("hold:done2", {31'd0, bus.done}, 32'd1);
      chk("hold:sum2", {16'd0, bus.sum}, 32'h5555);
      tick();

      // Invalid digit: err raised, sequence still completes
      run_op("t5", 16'h00A0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, cins);
      // Next valid start clears err
      run_op("t6", 16'h0450, 16'h0550, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b1, cins);

      // Async reset in the second RUN cycle
      bus.a_in  = 16'hA234;
      bus.b_in  = 16'h5678;
      bus.cin   = 1'b0;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      chk("ar:pre_sum", {16'd0, bus.sum}, 32'h0002);
      chk("ar:pre_err", {31'd0, bus.err}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar:busy", {31'd0, bus.busy}, 32'd0);
      chk("ar:done", {31'd0, bus.done}, 32'd0);
      chk("ar:sum", {16'd0, bus.sum}, 32'd0);
      chk("ar:cout", {31'd0, bus.cout}, 32'd0);
      chk("ar:err", {31'd0, bus.err}, 32'd0);
      tick();
      rst_n = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         seen = seen | bus.done | bus.busy;
      end
      chk("ar:no_done", {31'd0, seen}, 32'd0);

      // Recovery after reset
      run_op("t7", 16'h4321, 16'h5678, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, cins);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
